// File: rtl/pred_pack_writer.sv
// pred_pack_writer: packs 8-bit class predictions into 64-bit little-endian
// words, buffers them in a first-word fall-through FIFO, and streams them out
// over a valid/ready DMA write channel. A partial final word is zero-filled.
// Optional build macro: PRED_PACK_CHECKSUM_EN adds a running XOR of every
// word popped in the current burst on the checksum port.
module pred_pack_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] burst_len,
  input  logic        pred_valid,
  output logic        pred_ready,
  input  logic [7:0]  pred_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [31:0] words_expected,
  output logic        busy,
  output logic        done,
  output logic [63:0] checksum
);

  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       burst_l;
  logic [31:0]       sample_idx;
  logic [31:0]       burst_clamped;
  logic [31:0]       words_calc;
  logic [63:0]       pack_reg;
  logic [63:0]       word_nxt;
  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic              start_ok, accept, last_accept, push, pop;

  // Clamp the requested length and derive the word count for this burst
  always_comb begin
    burst_clamped = (burst_len > MAX_BURST_W) ? MAX_BURST_W : burst_len;
    words_calc    = 32'((33'(burst_clamped) + 33'd7) >> 3);
  end

  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == FIFO_FULL_CNT);
  // Ready is taken from the pre-pop FIFO level, so a full FIFO stalls input
  // for the cycle of the pop even though a slot is freed on that edge.
  assign pred_ready  = (state == PACK) && !fifo_full;
  assign accept      = pred_ready && pred_valid;
  assign last_accept = accept && (sample_idx == burst_l - 32'd1);
  assign push        = accept && ((sample_idx[2:0] == 3'd7) || last_accept);
  assign pop         = out_valid && out_ready;
  assign start_ok    = start && (state == IDLE);
  // The incoming byte lands in lane (sample_idx mod 8), lane 0 in bits 7:0
  assign word_nxt    = pack_reg | (64'(pred_data) << {sample_idx[2:0], 3'b000});

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? 64'd0 : fifo_mem[rd_ptr];
  assign busy      = (state == PACK) || (state == DRAIN);
  assign done      = (state == DONE);

  // Next-state logic for the burst controller
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (burst_clamped == 32'd0) ? DONE : PACK;
      PACK:    if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Burst bookkeeping: latched length, word count and sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_l        <= 32'd0;
      words_expected <= 32'd0;
      sample_idx     <= 32'd0;
    end else if (start_ok) begin
      burst_l        <= burst_clamped;
      words_expected <= words_calc;
      sample_idx     <= 32'd0;
    end else if (accept) begin
      sample_idx     <= sample_idx + 32'd1;
    end
  end

  // Pack register: accumulates bytes, cleared when its word is pushed
  always_ff @(posedge clk) begin
    if (start_ok)    pack_reg <= 64'd0;
    else if (accept) pack_reg <= push ? 64'd0 : word_nxt;
  end

  // FIFO storage; contents are qualified by the occupancy count
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= word_nxt;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef PRED_PACK_CHECKSUM_EN
  logic [63:0] csum_q;

  // Running XOR of every word leaving the FIFO in the current burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum_q <= 64'd0;
    else if (start_ok) csum_q <= 64'd0;
    else if (pop)      csum_q <= csum_q ^ out_data;
  end

  assign checksum = csum_q;
`else
  assign checksum = 64'd0;
`endif

endmodule

// File: tb/tb_pred_pack_writer.sv
// Testbench for pred_pack_writer: scenario tasks drive bursts, a scoreboard
// queue holds the words the bench expects and a monitor pops/compares them
// whenever the DUT hands a word over on the output channel.
module tb_pred_pack_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] burst_len;
  logic        pred_valid;
  logic        pred_ready;
  logic [7:0]  pred_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [31:0] words_expected;
  logic        busy;
  logic        done;
  logic [63:0] checksum;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pops  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] sb_exp;
  logic [63:0] m_word = 64'd0;
  int          m_lane = 0;

  pred_pack_writer #(.FIFO_DEPTH(4), .MAX_BURST(5000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .burst_len      (burst_len),
    .pred_valid     (pred_valid),
    .pred_ready     (pred_ready),
    .pred_data      (pred_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .words_expected (words_expected),
    .busy           (busy),
    .done           (done),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a handshake seen at the falling edge completes on
  // the next rising edge, so the popped word is compared here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_pops++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: got word %h, required no word", out_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (out_data !== sb_exp) begin
          n_fail++;
          $display("FAIL scoreboard_word: got %h, required %h", out_data, sb_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference packing model: little-endian lanes, word closes on lane 7 or last
  function automatic void model_add(input logic [7:0] d, input bit last);
    m_word = m_word | (64'(d) << (8 * m_lane));
    if (m_lane == 7 || last) begin
      exp_q.push_back(m_word);
      m_word = 64'd0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endfunction

  task automatic do_start(input logic [31:0] len);
    start     = 1'b1;
    burst_len = len;
    @(posedge clk); #1;
    start  = 1'b0;
    m_word = 64'd0;
    m_lane = 0;
  endtask

  // Offer one sample and hold it until accepted (bounded)
  task automatic push_sample(input logic [7:0] d, input bit last, output bit ok);
    pred_valid = 1'b1;
    pred_data  = d;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (pred_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    pred_valid = 1'b0;
    if (ok) model_add(d, last);
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; burst_len = 32'd0;
    pred_valid = 1'b0; pred_data = 8'd0; out_ready = 1'b0;
    #22;
    n_tests++;
    if ({out_valid, pred_ready, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got {ov,pr,busy,done}=%b, required 0000",
               {out_valid, pred_ready, busy, done});
    end
    n_tests++;
    if (out_data !== 64'd0) begin
      n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data);
    end
    n_tests++;
    if (words_expected !== 32'd0) begin
      n_fail++; $display("FAIL reset_words_expected: got %0d, required 0", words_expected);
    end
    n_tests++;
    if (checksum !== 64'd0) begin
      n_fail++; $display("FAIL reset_checksum: got %h, required 0", checksum);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_word();
    bit ok;
    int acc = 0;
    out_ready = 1'b1;
    do_start(32'd8);
    n_tests++;
    if (words_expected !== 32'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_start: got words_expected=%0d busy=%b, required 1 and 1",
               words_expected, busy);
    end
    for (int i = 0; i < 8; i++) begin
      push_sample(8'(i), i == 7, ok);
      acc += int'(ok);
    end
    n_tests++;
    if (acc !== 8) begin
      n_fail++; $display("FAIL full_accepts: got %0d, required 8", acc);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL full_latency: got out_valid=%b done=%b, required 1 and 0", out_valid, done);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drain: got ov=%b done=%b busy=%b, required 0 0 1", out_valid, done, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL full_done: got done=%b busy=%b, required 1 and 0", done, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL full_done_width: got done=%b, required 0", done);
    end
    n_tests++;
`ifdef PRED_PACK_CHECKSUM_EN
    if (checksum !== 64'h0706050403020100) begin
      n_fail++; $display("FAIL full_checksum: got %h, required 0706050403020100", checksum);
    end
`else
    if (checksum !== 64'd0) begin
      n_fail++; $display("FAIL full_checksum: got %h, required 0", checksum);
    end
`endif
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL full_leftover: got %0d words pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_partial();
    bit ok, seen;
    int acc = 0;
    out_ready = 1'b1;
    do_start(32'd3);
    push_sample(8'h01, 1'b0, ok); acc += int'(ok);
    // A start while a burst is running must be ignored
    do_start(32'd100);
    m_word = 64'h01; m_lane = 1;
    n_tests++;
    if (words_expected !== 32'd1) begin
      n_fail++; $display("FAIL partial_start_ignored: got words_expected=%0d, required 1", words_expected);
    end
    push_sample(8'h02, 1'b0, ok); acc += int'(ok);
    push_sample(8'h03, 1'b1, ok); acc += int'(ok);
    wait_done(20, seen);
    n_tests++;
    if (!seen || acc !== 3) begin
      n_fail++; $display("FAIL partial_done: got done_seen=%b accepts=%0d, required 1 and 3", seen, acc);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL partial_leftover: got %0d words pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_zero();
    int done_cnt = 0, first_at = 0, ov_cnt = 0, busy_cnt = 0;
    int pops0 = n_pops;
    out_ready = 1'b1;
    do_start(32'd0);
    n_tests++;
    if (words_expected !== 32'd0) begin
      n_fail++; $display("FAIL zero_words_expected: got %0d, required 0", words_expected);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (first_at == 0) first_at = k;
      end
      ov_cnt   += int'(out_valid);
      busy_cnt += int'(busy);
    end
    n_tests++;
    if (done_cnt !== 1 || first_at < 1 || first_at > 2) begin
      n_fail++;
      $display("FAIL zero_done: got %0d pulses first at cycle %0d, required 1 pulse within 2 cycles",
               done_cnt, first_at);
    end
    n_tests++;
    if (ov_cnt !== 0 || busy_cnt !== 0 || n_pops !== pops0) begin
      n_fail++;
      $display("FAIL zero_quiet: got out_valid cycles=%0d busy cycles=%0d, required 0 and 0",
               ov_cnt, busy_cnt);
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    bit rdy, seen;
    logic [63:0] held;
    int pops0 = n_pops;
    out_ready = 1'b0;
    do_start(32'd40);
    for (int c = 0; c < 45; c++) begin
      pred_valid = (acc < 40);
      pred_data  = 8'(acc);
      @(negedge clk);
      rdy = pred_ready && pred_valid;
      @(posedge clk); #1;
      if (rdy) begin
        model_add(8'(acc), acc == 39);
        acc++;
      end
    end
    n_tests++;
    if (acc !== 32) begin
      n_fail++; $display("FAIL stall_accepts: got %0d accepted, required 32", acc);
    end
    @(negedge clk);
    held = out_data;
    n_tests++;
    if (pred_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_full: got pred_ready=%b out_valid=%b, required 0 and 1",
                         pred_ready, out_valid);
    end
    n_tests++;
    if (held !== 64'h0706050403020100) begin
      n_fail++; $display("FAIL stall_head: got %h, required 0706050403020100", held);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_data !== held || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_hold: got %h valid=%b, required %h valid=1", out_data, out_valid, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && acc < 40; c++) begin
      pred_valid = 1'b1;
      pred_data  = 8'(acc);
      @(negedge clk);
      rdy = pred_ready;
      @(posedge clk); #1;
      if (rdy) begin
        model_add(8'(acc), acc == 39);
        acc++;
      end
    end
    pred_valid = 1'b0;
    wait_done(50, seen);
    n_tests++;
    if (!seen || acc !== 40 || (n_pops - pops0) !== 5) begin
      n_fail++;
      $display("FAIL stall_drain: got done_seen=%b accepts=%0d words=%0d, required 1 40 5",
               seen, acc, n_pops - pops0);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL stall_leftover: got %0d words pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    do_start(32'd20);
    for (int i = 0; i < 12; i++) push_sample(8'(i + 8'h40), 1'b0, ok);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, pred_ready, busy, done} !== 4'b0000 || out_data !== 64'd0 ||
        words_expected !== 32'd0 || checksum !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ov=%b pr=%b busy=%b done=%b data=%h we=%0d cs=%h, required all 0",
               out_valid, pred_ready, busy, done, out_data, words_expected, checksum);
    end
    exp_q.delete();
    m_word = 64'd0;
    m_lane = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    test_full_word();
  endtask

  task automatic test_clamp();
    bit ok, seen;
    int acc = 0, rdy_cnt = 0;
    out_ready = 1'b1;
    do_start(32'd6000);
    n_tests++;
    if (words_expected !== 32'd625) begin
      n_fail++; $display("FAIL clamp_words_expected: got %0d, required 625", words_expected);
    end
    for (int i = 0; i < 5000; i++) begin
      push_sample(8'(i * 3), i == 4999, ok);
      acc += int'(ok);
    end
    pred_valid = 1'b1;
    pred_data  = 8'hEE;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rdy_cnt += int'(pred_ready);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    pred_valid = 1'b0;
    n_tests++;
    if (acc !== 5000 || rdy_cnt !== 0 || !seen) begin
      n_fail++;
      $display("FAIL clamp_burst: got accepts=%0d extra_ready=%0d done_seen=%b, required 5000 0 1",
               acc, rdy_cnt, seen);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL clamp_leftover: got %0d words pending, required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

`ifdef PRED_PACK_CHECKSUM_EN
  task automatic test_checksum();
    bit ok, seen;
    out_ready = 1'b1;
    do_start(32'd16);
    for (int i = 0; i < 16; i++) push_sample(8'(i), i == 15, ok);
    wait_done(20, seen);
    n_tests++;
    if (!seen || checksum !== 64'h0808080808080808) begin
      n_fail++;
      $display("FAIL checksum_value: got done_seen=%b checksum=%h, required 1 and 0808080808080808",
               seen, checksum);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_zero();
    test_stall();
    test_reset_mid();
    test_clamp();
`ifdef PRED_PACK_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
